// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: NOP encoding and the IF->ID queue entry layout.
// No logic; types and constants only.
// Optional per-entry interrupt flag enabled by macro RISCV_FORMAL_INTR_EN.
package riscv_pkg;

    // Width of pc / pc_plus_4 fields in the queue entry.
    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0 -- presented on the ID side whenever nothing is buffered.
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
        logic [31:0]     insn;
`ifdef RISCV_FORMAL_INTR_EN
        logic            intr;
`endif
    } if_id_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue (DEPTH entries) with flush; optional intr flag via RISCV_FORMAL_INTR_EN.
// Latency: one cycle from push to presentation, no combinational in->out bypass.
// Backpressure: in_ready_o = not full from registered count only; push into a full queue waits for a pop.
module if_id_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = riscv_pkg::XLEN
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [XLEN-1:0]              in_pc_i,
    input  logic [XLEN-1:0]              in_pc_plus_4_i,
    input  logic [31:0]                  in_insn_i,
`ifdef RISCV_FORMAL_INTR_EN
    input  logic                         in_intr_i,
    output logic                         out_intr_o,
`endif
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [XLEN-1:0]              out_pc_o,
    output logic [XLEN-1:0]              out_pc_plus_4_o,
    output logic [31:0]                  out_insn_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    import riscv_pkg::*;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    if_id_entry_t  mem_q [DEPTH];
    if_id_entry_t  in_entry;
    if_id_entry_t  head;

    // Handshake qualifiers; flush suppresses both sides for the cycle.
    always_comb begin
        in_ready_o  = (count_q != FULL_CNT);
        out_valid_o = (count_q != '0);
        push        = in_valid_i && in_ready_o && !flush_i;
        pop         = out_valid_o && out_ready_i && !flush_i;
        count_o     = count_q;
    end

    // Pack the IF payload into one storage entry.
    always_comb begin
        in_entry           = '0;
        in_entry.pc        = in_pc_i;
        in_entry.pc_plus_4 = in_pc_plus_4_i;
        in_entry.insn      = in_insn_i;
`ifdef RISCV_FORMAL_INTR_EN
        in_entry.intr      = in_intr_i;
`endif
    end

    // Pointer and occupancy state; flush returns everything to the empty origin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // Payload storage is never read while empty, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    // Present the head entry, or the canonical empty values when nothing is buffered.
    always_comb begin
        head            = mem_q[rd_ptr_q];
        out_pc_o        = '0;
        out_pc_plus_4_o = '0;
        out_insn_o      = NOP_INSTRUCTION;
`ifdef RISCV_FORMAL_INTR_EN
        out_intr_o      = 1'b0;
`endif
        if (out_valid_o) begin
            out_pc_o        = head.pc;
            out_pc_plus_4_o = head.pc_plus_4;
            out_insn_o      = head.insn;
`ifdef RISCV_FORMAL_INTR_EN
            out_intr_o      = head.intr;
`endif
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=2): vector table plus hand sequences for reset/intr.
// Checks sampled 1 time unit after each rising edge; inputs driven on the falling edge.
// Summary line reports vectors applied and miscompares.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_pc_i;
    logic [31:0] in_pc_plus_4_i;
    logic [31:0] in_insn_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_pc_o;
    logic [31:0] out_pc_plus_4_o;
    logic [31:0] out_insn_o;
    logic [1:0]  count_o;
`ifdef RISCV_FORMAL_INTR_EN
    logic        in_intr_i;
    logic        out_intr_o;
`endif

    int applied = 0;
    int miscompares = 0;

    if_id_queue #(.DEPTH(2), .XLEN(32)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_pc_i         (in_pc_i),
        .in_pc_plus_4_i  (in_pc_plus_4_i),
        .in_insn_i       (in_insn_i),
`ifdef RISCV_FORMAL_INTR_EN
        .in_intr_i       (in_intr_i),
        .out_intr_o      (out_intr_o),
`endif
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_pc_o        (out_pc_o),
        .out_pc_plus_4_o (out_pc_plus_4_o),
        .out_insn_o      (out_insn_o),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        e_valid;
        logic        e_ready;
        logic [1:0]  e_count;
        logic [31:0] e_pc;
        logic [31:0] e_insn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] pc, input logic [31:0] insn,
                       input logic ev, input logic er, input logic [1:0] ec,
                       input logic [31:0] epc, input logic [31:0] einsn);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc; v.insn = insn;
        v.e_valid = ev; v.e_ready = er; v.e_count = ec; v.e_pc = epc; v.e_insn = einsn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Compare all visible outputs against an expected empty/non-empty state.
    task automatic chk_state(input string tag, input logic ev, input logic er,
                             input logic [1:0] ec, input logic [31:0] epc, input logic [31:0] einsn);
        chk({tag, ".out_valid"}, 64'(out_valid_o), 64'(ev));
        chk({tag, ".in_ready"},  64'(in_ready_o),  64'(er));
        chk({tag, ".count"},     64'(count_o),     64'(ec));
        chk({tag, ".out_pc"},    64'(out_pc_o),    64'(epc));
        chk({tag, ".out_pc4"},   64'(out_pc_plus_4_o), 64'(ev ? epc + 32'd4 : 32'd0));
        chk({tag, ".out_insn"},  64'(out_insn_o),  64'(einsn));
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [31:0] pc, input logic [31:0] insn);
        @(negedge clk_i);
        in_valid_i     = iv;
        out_ready_i    = ordy;
        flush_i        = fl;
        in_pc_i        = pc;
        in_pc_plus_4_i = pc + 32'd4;
        in_insn_i      = insn;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_pc_i = '0; in_pc_plus_4_i = '0; in_insn_i = '0;
`ifdef RISCV_FORMAL_INTR_EN
        in_intr_i = 1'b0;
`endif
        #1;
        chk_state("reset", 1'b0, 1'b1, 2'd0, 32'h0, NOP);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Single push, fill to full, ignored third push, drain in order.
        add(1, 0, 0, 32'h100, 32'h0050_0093, 1, 1, 2'd1, 32'h100, 32'h0050_0093);
        add(1, 0, 0, 32'h104, 32'h0060_0113, 1, 0, 2'd2, 32'h100, 32'h0050_0093);
        add(1, 0, 0, 32'h108, 32'h0070_0193, 1, 0, 2'd2, 32'h100, 32'h0050_0093);
        add(0, 1, 0, 32'h0,   32'h0,         1, 1, 2'd1, 32'h104, 32'h0060_0113);
        add(0, 1, 0, 32'h0,   32'h0,         0, 1, 2'd0, 32'h0,   NOP);
        // Streaming: one per cycle, count stays 1, pointers wrap.
        for (int k = 0; k < 8; k++)
            add(1, 1, 0, 32'h200 + 32'(4 * k), 32'h0000_0093 + 32'(k << 20),
                1, 1, 2'd1, 32'h200 + 32'(4 * k), 32'h0000_0093 + 32'(k << 20));
        add(0, 1, 0, 32'h0, 32'h0, 0, 1, 2'd0, 32'h0, NOP);
        // Full with out_ready=1: no push that cycle, push only after the pop.
        add(1, 0, 0, 32'h400, 32'hAAAA_0013, 1, 1, 2'd1, 32'h400, 32'hAAAA_0013);
        add(1, 0, 0, 32'h404, 32'hBBBB_0013, 1, 0, 2'd2, 32'h400, 32'hAAAA_0013);
        add(1, 1, 0, 32'h408, 32'hCCCC_0013, 1, 1, 2'd1, 32'h404, 32'hBBBB_0013);
        add(1, 1, 0, 32'h408, 32'hCCCC_0013, 1, 1, 2'd1, 32'h408, 32'hCCCC_0013);
        add(0, 1, 0, 32'h0,   32'h0,         0, 1, 2'd0, 32'h0,   NOP);
        // Flush with a presented input: everything dropped, 0x300 never appears.
        add(1, 0, 0, 32'h2F0, 32'h1111_0013, 1, 1, 2'd1, 32'h2F0, 32'h1111_0013);
        add(1, 0, 0, 32'h2F4, 32'h2222_0013, 1, 0, 2'd2, 32'h2F0, 32'h1111_0013);
        add(1, 1, 1, 32'h300, 32'h3333_0013, 0, 1, 2'd0, 32'h0,   NOP);
        add(0, 0, 0, 32'h0,   32'h0,         0, 1, 2'd0, 32'h0,   NOP);
        add(1, 0, 0, 32'h310, 32'h4444_0013, 1, 1, 2'd1, 32'h310, 32'h4444_0013);
        add(0, 1, 0, 32'h0,   32'h0,         0, 1, 2'd0, 32'h0,   NOP);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].pc, vecs[i].insn);
            @(posedge clk_i);
            #1;
            chk_state($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                      vecs[i].e_count, vecs[i].e_pc, vecs[i].e_insn);
        end

        // Asynchronous reset between edges with two entries buffered.
        drive(1, 0, 0, 32'h500, 32'h5555_0013);
        @(posedge clk_i);
        drive(1, 0, 0, 32'h504, 32'h6666_0013);
        @(posedge clk_i);
        #1;
        chk("pre_rst.count", 64'(count_o), 64'd2);
        #2;
        rst_ni = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 1'b1, 2'd0, 32'h0, NOP);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk_state("post_rst_idle", 1'b0, 1'b1, 2'd0, 32'h0, NOP);
        drive(1, 0, 0, 32'h600, 32'h7777_0013);
        @(posedge clk_i);
        #1;
        chk_state("post_rst_push", 1'b1, 1'b1, 2'd1, 32'h600, 32'h7777_0013);
        drive(0, 1, 0, 32'h0, 32'h0);
        @(posedge clk_i);
        #1;
        chk_state("post_rst_drain", 1'b0, 1'b1, 2'd0, 32'h0, NOP);

`ifdef RISCV_FORMAL_INTR_EN
        // Interrupt flag travels with its entry and reads 0 when empty.
        in_intr_i = 1'b1;
        drive(1, 0, 0, 32'h700, 32'h8888_0013);
        @(posedge clk_i);
        in_intr_i = 1'b0;
        drive(1, 0, 0, 32'h704, 32'h9999_0013);
        @(posedge clk_i);
        #1;
        chk("intr.first", 64'(out_intr_o), 64'd1);
        drive(0, 1, 0, 32'h0, 32'h0);
        @(posedge clk_i);
        #1;
        chk("intr.second", 64'(out_intr_o), 64'd0);
        chk("intr.second_pc", 64'(out_pc_o), 64'h704);
        @(posedge clk_i);
        #1;
        chk("intr.empty", 64'(out_intr_o), 64'd0);
        chk("intr.empty_valid", 64'(out_valid_o), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of buffered IF->ID entries (power of two, >= 2).
REQ-002 The block SHALL have parameter XLEN, default 32, giving the pc/pc_plus_4 width; insn SHALL be fixed at 32 bits.
REQ-003 The block SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have port flush_i  in  1  synchronous discard of all entries.
REQ-006 The block SHALL have ports in_valid_i  in  1 / in_ready_o  out  1  IF-side handshake.
REQ-007 The block SHALL have ports in_pc_i  in  XLEN, in_pc_plus_4_i  in  XLEN, and in_insn_i  in  32  as the IF payload.
REQ-008 The block SHALL have ports out_valid_o  out  1 / out_ready_i  in  1  ID-side handshake.
REQ-009 The block SHALL have ports out_pc_o  out  XLEN, out_pc_plus_4_o  out  XLEN, and out_insn_o  out  32  as the head-entry payload.
REQ-010 The block SHALL have port count_o  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-011 Push SHALL occur on a rising edge when in_valid_i && in_ready_o && !flush_i; pop SHALL occur when out_valid_o && out_ready_i && !flush_i.
REQ-012 in_ready_o SHALL equal (count_o != DEPTH), combinationally from registered count only, with no dependence on out_ready_i.
REQ-013 out_valid_o SHALL equal (count_o != 0); payload outputs SHALL be driven from the head entry.
REQ-014 When empty, out_pc_o and out_pc_plus_4_o SHALL be 0 and out_insn_o SHALL be NOP_INSTRUCTION.
REQ-015 Latency SHALL be one cycle: an entry pushed into an empty queue is presented at out_* on the next cycle; there is no combinational in->out bypass.
REQ-016 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-017 With the queue full, in_ready_o SHALL be 0 even if out_ready_i=1; a push SHALL be possible only on the cycle after a pop.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH without a bubble.
REQ-019 Data SHALL leave in strict push order; a held head (out_ready_i=0) SHALL keep out_* stable.
REQ-020 flush_i SHALL take priority over push and pop in the same cycle: the next-cycle count is 0, both pointers are 0, and the presented input is dropped.
REQ-021 Payload registers SHALL NOT require reset; only pointers and count are reset.

Reset
REQ-022 Asserting rst_ni low SHALL immediately force count=0 and pointers=0, so that out_valid_o=0, in_ready_o=1, count_o=0, and outputs equal the empty values of REQ-014.
REQ-023 Reset asserted mid-transfer SHALL discard all entries; no push SHALL be accepted on the first edge after deassertion unless in_valid_i is sampled high then.

Configuration
REQ-024 Macro RISCV_FORMAL_INTR_EN, when defined, SHALL add ports in_intr_i  in  1 and out_intr_o  out  1, carried per entry like insn; out_intr_o SHALL be 0 when empty.
REQ-025 Without RISCV_FORMAL_INTR_EN, the block SHALL have no intr ports or storage, and its behaviour SHALL otherwise be identical.

Structure
REQ-026 NOP_INSTRUCTION and a packed typedef if_id_entry_t {pc, pc_plus_4, insn[, intr]} SHALL live in riscv_pkg; XLEN-dependent fields SHALL be expressed in a package parameter.
REQ-027 Storage SHALL be an inline register array of if_id_entry_t with no sub-module; pointer/count logic SHALL stay in this module.

Verification
REQ-028 Reset then push pc=0x100 insn=0x00500093 with out_ready=0 -> next cycle out_valid=1, out_pc=0x100, count=1, in_ready=1.
REQ-029 DEPTH=2 with out_ready=0: push 0x100 and 0x104 -> count=2, in_ready=0; a third push of 0x108 is ignored; then out_ready=1 -> 0x100, then 0x104, then empty (out_insn=NOP_INSTRUCTION).
REQ-030 Steady state with in_valid=1 and out_ready=1 for 8 pushes 0x200..0x21C -> one per cycle in order, count stays 1, pointers wrap cleanly.
REQ-031 Queue holding 2 entries, flush=1 with in_valid=1 pc=0x300 -> next cycle count=0, out_valid=0; 0x300 never appears.
REQ-032 rst_ni pulled low between clock edges with count=2 -> out_valid falls before the next edge and count_o=0.
REQ-033 With RISCV_FORMAL_INTR_EN defined, push intr=1 then intr=0 -> out_intr follows 1,0 in order, and 0 when empty.
